// File: rtl/gelato_scoreboard_pkg.sv
// Shared types and default sizes for the Gelato SM per-warp register scoreboard.
// The table typedef is also used by the warp scheduler's scoreboard interface.
package gelato_scoreboard_pkg;

    localparam int WARP_NUM_DEF = 4;
    localparam int SB_SIZE_DEF  = 4;
    localparam int WB_PORTS_DEF = 3;
    localparam int REG_W_DEF    = 5;
    localparam int WARP_W_DEF   = $clog2(WARP_NUM_DEF);

    typedef logic [REG_W_DEF-1:0]  reg_num_t;
    typedef logic [WARP_W_DEF-1:0] warp_num_t;
    typedef reg_num_t              sb_entry_t;

    typedef sb_entry_t [WARP_NUM_DEF-1:0][SB_SIZE_DEF-1:0] sb_table_t;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Round-robin arbiter: searches from the last grant + 1 with wrap-around.
// The pointer only advances on a grant, so an idle cycle keeps the fairness order.
module gelato_rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [PW-1:0] gnt_idx
);

    localparam int unsigned NU = N;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] cand;

    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_idx   = ptr_q;
        cand      = '0;
        for (int unsigned off = 1; off <= NU; off++) begin
            cand = PW'((32'(ptr_q) + off) % NU);
            if (en && !gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
        ptr_d = gnt_valid ? gnt_idx : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gelato_scoreboard.sv
// Per-warp register scoreboard: records issued destination registers and clears
// them on writeback, with one shared release path arbitrated round-robin.
module gelato_scoreboard
    import gelato_scoreboard_pkg::*;
#(
    parameter int WARP_NUM = WARP_NUM_DEF,
    parameter int SB_SIZE  = SB_SIZE_DEF,
    parameter int WB_PORTS = WB_PORTS_DEF,
    parameter int REG_W    = REG_W_DEF,
    parameter int WARP_W   = $clog2(WARP_NUM)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     rdy,
    input  logic                                     alloc_valid,
    input  logic [WARP_W-1:0]                        alloc_warp,
    input  logic [REG_W-1:0]                         alloc_rd,
    output logic                                     alloc_ready,
    input  logic [WB_PORTS-1:0]                      wb_valid,
    input  logic [WB_PORTS-1:0][WARP_W-1:0]          wb_warp,
    input  logic [WB_PORTS-1:0][REG_W-1:0]           wb_rd,
    output logic [WB_PORTS-1:0]                      wb_ready,
    output logic [WARP_NUM-1:0][SB_SIZE-1:0][REG_W-1:0] regs,
    output logic [WARP_NUM-1:0]                      full,
    output logic                                     err
);

    localparam int IW = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
    localparam int SW = (SB_SIZE > 1) ? $clog2(SB_SIZE) : 1;
    localparam int unsigned SBU = SB_SIZE;
    localparam int unsigned WNU = WARP_NUM;

    logic [WARP_NUM-1:0][SB_SIZE-1:0][REG_W-1:0] table_q, table_d;
    logic [WARP_NUM-1:0] full_q, full_d;
    logic                err_q, err_d;

    logic [WB_PORTS-1:0] gnt;
    logic                gnt_valid;
    logic [IW-1:0]       gnt_idx;

    logic                alloc_hs;
    logic [WARP_W-1:0]   rel_warp;
    logic [REG_W-1:0]    rel_rd;
    logic                free_found, match_found;
    logic [SW-1:0]       free_idx, match_idx;

    gelato_rr_arbiter #(.N(WB_PORTS)) u_wb_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .req       (wb_valid),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        alloc_ready = rdy && (alloc_rd == '0 || !full_q[alloc_warp]);
        alloc_hs    = alloc_valid && alloc_ready;
        rel_warp    = wb_warp[gnt_idx];
        rel_rd      = wb_rd[gnt_idx];

        // Both searches look at pre-edge state so a slot freed this cycle is not reused.
        free_found  = 1'b0;
        free_idx    = '0;
        match_found = 1'b0;
        match_idx   = '0;
        for (int unsigned s = 0; s < SBU; s++) begin
            if (!free_found && table_q[alloc_warp][SW'(s)] == '0) begin
                free_found = 1'b1;
                free_idx   = SW'(s);
            end
            if (!match_found && table_q[rel_warp][SW'(s)] == rel_rd) begin
                match_found = 1'b1;
                match_idx   = SW'(s);
            end
        end

        table_d = table_q;
        err_d   = err_q;
        if (gnt_valid) begin
            if (rel_rd != '0 && match_found) begin
                table_d[rel_warp][match_idx] = '0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (alloc_hs && alloc_rd != '0 && free_found) begin
            table_d[alloc_warp][free_idx] = alloc_rd;
        end

        full_d = '0;
        for (int unsigned w = 0; w < WNU; w++) begin
            full_d[WARP_W'(w)] = 1'b1;
            for (int unsigned s = 0; s < SBU; s++) begin
                if (table_d[WARP_W'(w)][SW'(s)] == '0) begin
                    full_d[WARP_W'(w)] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_q <= '0;
            full_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            table_q <= table_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign wb_ready = gnt;
    assign regs     = table_q;
    assign full     = full_q;
    assign err      = err_q;

endmodule

// File: tb/tb_gelato_scoreboard.sv
// Self-checking bench for gelato_scoreboard: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural table/arbiter model.
module tb_gelato_scoreboard;

    localparam int NW = 4;
    localparam int SB = 4;
    localparam int WP = 3;
    localparam int RW = 5;
    localparam int WW = 2;

    logic clk = 1'b0;
    logic rst, rdy, alloc_valid, alloc_ready, err;
    logic [WW-1:0] alloc_warp;
    logic [RW-1:0] alloc_rd;
    logic [WP-1:0] wb_valid, wb_ready;
    logic [WP-1:0][WW-1:0] wb_warp;
    logic [WP-1:0][RW-1:0] wb_rd;
    logic [NW-1:0][SB-1:0][RW-1:0] regs;
    logic [NW-1:0] full;

    int tests = 0;
    int fails = 0;

    int m_tab[NW][SB];
    bit m_err;
    int m_last;
    int last_g;

    always #5 clk = ~clk;

    gelato_scoreboard #(
        .WARP_NUM (NW),
        .SB_SIZE  (SB),
        .WB_PORTS (WP),
        .REG_W    (RW),
        .WARP_W   (WW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .alloc_valid (alloc_valid),
        .alloc_warp  (alloc_warp),
        .alloc_rd    (alloc_rd),
        .alloc_ready (alloc_ready),
        .wb_valid    (wb_valid),
        .wb_warp     (wb_warp),
        .wb_rd       (wb_rd),
        .wb_ready    (wb_ready),
        .regs        (regs),
        .full        (full),
        .err         (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_full(input int w);
        for (int s = 0; s < SB; s++) if (m_tab[w][s] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_alloc_ready();
        return rdy && (alloc_rd == 0 || !m_full(int'(alloc_warp)));
    endfunction

    function automatic int exp_grant();
        if (!rdy) return -1;
        for (int k = 1; k <= WP; k++) begin
            int p;
            p = (m_last + k) % WP;
            if (wb_valid[p]) return p;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < SB; s++) m_tab[w][s] = 0;
        m_err  = 1'b0;
        m_last = WP - 1;
    endtask

    task automatic check_all();
        int eg;
        logic [WP-1:0] ew;
        eg = exp_grant();
        ew = '0;
        if (eg >= 0) ew[eg] = 1'b1;
        check("alloc_ready", 64'(alloc_ready), 64'(exp_alloc_ready()));
        check("wb_ready", 64'(wb_ready), 64'(ew));
        for (int w = 0; w < NW; w++) begin
            for (int s = 0; s < SB; s++)
                check($sformatf("regs[%0d][%0d]", w, s), 64'(regs[w][s]), 64'(m_tab[w][s]));
            check($sformatf("full[%0d]", w), 64'(full[w]), 64'(m_full(w)));
        end
        check("err", 64'(err), 64'(m_err));
    endtask

    // One cycle: compare before the edge, then apply the spec's rules to the model.
    task automatic step();
        int g, fs, ms, w, r;
        bit ahs;
        if (rst) m_reset();
        #1;
        check_all();
        g   = rst ? -1 : exp_grant();
        ahs = !rst && alloc_valid && exp_alloc_ready();
        @(posedge clk);
        last_g = g;
        if (!rst) begin
            fs = -1;
            if (ahs && alloc_rd != 0)
                for (int s = 0; s < SB; s++)
                    if (fs < 0 && m_tab[alloc_warp][s] == 0) fs = s;
            if (g >= 0) begin
                ms = -1;
                w  = int'(wb_warp[g]);
                r  = int'(wb_rd[g]);
                if (r != 0)
                    for (int s = 0; s < SB; s++)
                        if (ms < 0 && m_tab[w][s] == r) ms = s;
                if (ms >= 0) m_tab[w][ms] = 0;
                else m_err = 1'b1;
                m_last = g;
            end
            if (fs >= 0) m_tab[alloc_warp][fs] = int'(alloc_rd);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rdy = 1'b1; alloc_valid = 1'b0; alloc_warp = '0; alloc_rd = '0;
        wb_valid = '0; wb_warp = '0; wb_rd = '0;
    endtask

    task automatic do_alloc(input int w, input int r);
        alloc_valid = 1'b1; alloc_warp = WW'(w); alloc_rd = RW'(r);
        step();
        alloc_valid = 1'b0;
    endtask

    initial begin
        int seq[6] = '{0, 1, 2, 0, 1, 2};
        int gcnt[WP];
        bit pv[WP];
        int pw[WP];
        int pr[WP];

        rst = 1'b1;
        idle();
        m_reset();
        @(negedge clk);
        step();
        check("reset_err", 64'(err), 64'd0);
        check("reset_regs", 64'(regs), 64'd0);
        rst = 1'b0;
        step();

        do_alloc(1, 5);
        do_alloc(1, 7);
        check("w1_slot0", 64'(regs[1][0]), 64'd5);
        check("w1_slot1", 64'(regs[1][1]), 64'd7);
        check("w1_err", 64'(err), 64'd0);

        for (int i = 0; i < SB; i++) do_alloc(0, 10 + i);
        check("w0_full", 64'(full[0]), 64'd1);
        alloc_valid = 1'b1; alloc_warp = 2'd0; alloc_rd = 5'd3;
        #1 check("full_stall", 64'(alloc_ready), 64'd0);
        step();
        alloc_rd = 5'd0;
        #1 check("rd0_ready", 64'(alloc_ready), 64'd1);
        step();
        alloc_valid = 1'b0;
        check("w0_slot3", 64'(regs[0][3]), 64'd13);

        wb_valid = 3'b111; wb_warp = '0;
        wb_rd[0] = 5'd10; wb_rd[1] = 5'd11; wb_rd[2] = 5'd12;
        for (int p = 0; p < WP; p++) gcnt[p] = 0;
        for (int i = 0; i < 6; i++) begin
            #1 check($sformatf("rr_grant%0d", i), 64'(wb_ready), 64'(1 << seq[i]));
            step();
            gcnt[seq[i]]++;
            if (gcnt[seq[i]] == 1) begin
                case (seq[i])
                    0: begin wb_warp[0] = 2'd0; wb_rd[0] = 5'd13; end
                    1: begin wb_warp[1] = 2'd1; wb_rd[1] = 5'd5; end
                    default: begin wb_warp[2] = 2'd1; wb_rd[2] = 5'd7; end
                endcase
            end else begin
                wb_valid[seq[i]] = 1'b0;
            end
        end
        check("rr_w0_empty", 64'(regs[0]), 64'd0);
        check("rr_w1_empty", 64'(regs[1]), 64'd0);
        check("rr_err", 64'(err), 64'd0);

        do_alloc(2, 1); do_alloc(2, 4); do_alloc(2, 5); do_alloc(2, 6);
        wb_valid = 3'b001; wb_warp[0] = 2'd2; wb_rd[0] = 5'd4;
        alloc_valid = 1'b1; alloc_warp = 2'd2; alloc_rd = 5'd9;
        #1 check("same_cyc_stall", 64'(alloc_ready), 64'd0);
        check("same_cyc_grant", 64'(wb_ready), 64'd1);
        step();
        wb_valid = '0;
        check("rel_slot1", 64'(regs[2][1]), 64'd0);
        check("rel_notfull", 64'(full[2]), 64'd0);
        #1 check("retry_ready", 64'(alloc_ready), 64'd1);
        step();
        alloc_valid = 1'b0;
        check("reuse_slot1", 64'(regs[2][1]), 64'd9);
        check("refull", 64'(full[2]), 64'd1);

        wb_valid = 3'b010; wb_warp[1] = 2'd3; wb_rd[1] = 5'd6;
        step();
        wb_valid = '0;
        check("nomatch_err", 64'(err), 64'd1);
        step();
        check("err_sticky", 64'(err), 64'd1);

        rdy = 1'b0;
        alloc_valid = 1'b1; alloc_warp = 2'd3; alloc_rd = 5'd2;
        wb_valid = 3'b111; wb_warp = {2'd2, 2'd2, 2'd2}; wb_rd = {5'd5, 5'd5, 5'd5};
        #1 check("rdy0_alloc", 64'(alloc_ready), 64'd0);
        check("rdy0_wb", 64'(wb_ready), 64'd0);
        step();
        step();
        check("rdy0_stable", 64'(regs[2][2]), 64'd5);
        idle();

        do_alloc(3, 8);
        do_alloc(3, 9);
        alloc_valid = 1'b1; alloc_warp = 2'd3; alloc_rd = 5'd10;
        rst = 1'b1;
        #1 check("async_rst_regs", 64'(regs), 64'd0);
        check("async_rst_err", 64'(err), 64'd0);
        step();
        rst = 1'b0;
        idle();
        step();

        for (int p = 0; p < WP; p++) pv[p] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            alloc_valid = ($urandom_range(0, 9) < 4);
            alloc_warp  = WW'($urandom_range(0, NW - 1));
            alloc_rd    = RW'(($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 12));
            for (int p = 0; p < WP; p++) begin
                if (!pv[p] && $urandom_range(0, 1) == 1) begin
                    int cand[$];
                    pv[p] = 1'b1;
                    pw[p] = $urandom_range(0, NW - 1);
                    for (int s = 0; s < SB; s++)
                        if (m_tab[pw[p]][s] != 0) cand.push_back(m_tab[pw[p]][s]);
                    if ($urandom_range(0, 29) == 0) pr[p] = 0;
                    else if (cand.size() > 0 && $urandom_range(0, 9) != 0)
                        pr[p] = cand[$urandom_range(0, cand.size() - 1)];
                    else pr[p] = $urandom_range(1, 31);
                end
                wb_valid[p] = pv[p];
                wb_warp[p]  = WW'(pw[p]);
                wb_rd[p]    = RW'(pr[p]);
            end
            step();
            if (rst) begin
                for (int p = 0; p < WP; p++) pv[p] = 1'b0;
            end else if (last_g >= 0) begin
                pv[last_g] = 1'b0;
            end
        end
        rst = 1'b0;
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
